// File: rtl/ex_inflight_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_inflight_scoreboard_if
// Purpose  : Issue / retire / kill signal bundle between the ID-stage control
//            and the in-flight instruction scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
interface ex_inflight_scoreboard_if #(
  parameter int CNT_W = 3
);
  logic             Issue_Valid;
  logic             Issue_RegWrite;
  logic [4:0]       Issue_Dst;
  logic             Issue_IsLoad;
  logic [4:0]       Src_rs;
  logic [4:0]       Src_rt;
  logic             Src_rs_used;
  logic             Src_rt_used;
  logic             Retire_Valid;
  logic [4:0]       Retire_Dst;
  logic             Kill_Young;
  logic             Stall;
  logic [CNT_W-1:0] Pending_Count;
  logic             Full;
  logic             Error;

  // Pipeline control side: drives issue/retire/kill, observes stall/status
  modport master (
    output Issue_Valid, Issue_RegWrite, Issue_Dst, Issue_IsLoad,
    output Src_rs, Src_rt, Src_rs_used, Src_rt_used,
    output Retire_Valid, Retire_Dst, Kill_Young,
    input  Stall, Pending_Count, Full, Error
  );

  // Scoreboard side
  modport slave (
    input  Issue_Valid, Issue_RegWrite, Issue_Dst, Issue_IsLoad,
    input  Src_rs, Src_rt, Src_rs_used, Src_rt_used,
    input  Retire_Valid, Retire_Dst, Kill_Young,
    output Stall, Pending_Count, Full, Error
  );
endinterface
`default_nettype wire

// File: rtl/ex_inflight_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : ex_inflight_scoreboard
// Purpose  : Age-ordered FIFO of instructions in flight between EX1 and WB.
//            Generates the ID stall for load-use hazards and full occupancy,
//            drops the youngest entry on a Jump/JR squash and flags protocol
//            violations (retire/kill on empty, retire destination mismatch).
// Revision : 1.0 - initial release
// ============================================================================
module ex_inflight_scoreboard #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                    Clk,
  input  logic                    Reset,
  ex_inflight_scoreboard_if.slave sb
);

  localparam int               c_ptr_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_one_cnt   = CNT_W'(1);

  // Entry storage; r_occ marks slots currently holding a live instruction
  logic [DEPTH-1:0]   r_occ;
  logic [DEPTH-1:0]   r_vdst;
  logic [DEPTH-1:0]   r_load;
  logic [4:0]         r_dst [DEPTH];
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               r_error;

  logic               w_hazard;
  logic               w_empty;
  logic               w_full;
  logic               w_stall;
  logic               w_push;
  logic               w_kill;
  logic               w_pop;
  logic               w_single_both;
  logic               w_retire_mismatch;
  logic               w_proto_err;
  logic [c_ptr_w-1:0] w_kill_ptr;
  logic [c_ptr_w-1:0] w_push_ptr;
  logic [CNT_W-1:0]   w_count_nxt;

  // Load-use search: any live load with a real destination matching a used source
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_occ[i] && r_vdst[i] && r_load[i]) begin
        if (sb.Src_rs_used && (sb.Src_rs != 5'd0) && (sb.Src_rs == r_dst[i]))
          w_hazard = 1'b1;
        if (sb.Src_rt_used && (sb.Src_rt != 5'd0) && (sb.Src_rt == r_dst[i]))
          w_hazard = 1'b1;
      end
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth_cnt);

  // Stall looks only at registered state; a retire this cycle does not free a slot early
  assign w_stall = w_full | w_hazard;
  assign w_push  = sb.Issue_Valid & ~w_stall;
  assign w_kill  = sb.Kill_Young & ~w_empty;

  // With a single entry, retire and kill name the same instruction: remove it once,
  // via the kill path, and skip the retire destination check.
  assign w_single_both = w_kill & sb.Retire_Valid & (r_count == c_one_cnt);
  assign w_pop         = sb.Retire_Valid & ~w_empty & ~w_single_both;

  // Kill happens before the push, so a same-cycle issue reuses the killed slot
  assign w_kill_ptr = r_tail - c_ptr_w'(1);
  assign w_push_ptr = w_kill ? w_kill_ptr : r_tail;

  assign w_retire_mismatch = w_pop & r_vdst[r_head] & (r_dst[r_head] != sb.Retire_Dst);
  assign w_proto_err       = (sb.Retire_Valid & w_empty) | (sb.Kill_Young & w_empty) |
                             w_retire_mismatch;

  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop) - CNT_W'(w_kill);

  // Pointer, occupancy count and sticky error bookkeeping
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_pop)
        r_head <= r_head + c_ptr_w'(1);
      r_tail  <= w_push ? (w_push_ptr + c_ptr_w'(1)) : w_push_ptr;
      r_count <= w_count_nxt;
      if (w_proto_err)
        r_error <= 1'b1;
    end
  end

  // Entry contents: clear on retire/kill, then write the issuing instruction
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_occ  <= '0;
      r_vdst <= '0;
      r_load <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_dst[i] <= 5'd0;
    end else begin
      if (w_pop)
        r_occ[r_head] <= 1'b0;
      if (w_kill)
        r_occ[w_kill_ptr] <= 1'b0;
      if (w_push) begin
        r_occ[w_push_ptr]  <= 1'b1;
        r_vdst[w_push_ptr] <= sb.Issue_RegWrite & (sb.Issue_Dst != 5'd0);
        r_dst[w_push_ptr]  <= sb.Issue_Dst;
        r_load[w_push_ptr] <= sb.Issue_IsLoad;
      end
    end
  end

  assign sb.Stall         = w_stall;
  assign sb.Pending_Count = r_count;
  assign sb.Full          = w_full;
  assign sb.Error         = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ex_inflight_scoreboard.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ex_inflight_scoreboard
// Purpose  : Self-checking bench for ex_inflight_scoreboard. A queue-based
//            reference model predicts Stall/count/Full/Error each cycle; a
//            negedge monitor pops and compares the predictions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_inflight_scoreboard;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  // Clock generation
  always #5 Clk = ~Clk;

  ex_inflight_scoreboard_if #(.CNT_W(CNT_W)) sb_if ();

  ex_inflight_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .sb    (sb_if)
  );

  typedef struct {
    logic [4:0] dst;
    bit         wr;
    bit         ld;
  } ent_t;

  typedef struct {
    bit stall;
    int cnt;
    bit full;
    bit err;
    int id;
  } exp_t;

  ent_t mq[$];
  exp_t eq[$];
  bit   m_err = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   step_no = 0;

  // Next-cycle stimulus
  bit         n_rst, n_iv, n_wr, n_ld, n_rsu, n_rtu, n_rv, n_kill;
  logic [4:0] n_dst, n_rs, n_rt, n_rd;

  task automatic chk(input string nm, input int act, input int expv, input int id);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s step=%0d got=%0d want=%0d", nm, id, act, expv);
    end
  endtask

  task automatic clr();
    n_rst = 0; n_iv = 0; n_wr = 0; n_ld = 0; n_rsu = 0; n_rtu = 0; n_rv = 0; n_kill = 0;
    n_dst = 5'd0; n_rs = 5'd0; n_rt = 5'd0; n_rd = 5'd0;
  endtask

  function automatic bit model_stall();
    bit st;
    st = (mq.size() == DEPTH);
    foreach (mq[i]) begin
      if (mq[i].ld && mq[i].wr && mq[i].dst != 5'd0) begin
        if (n_rsu && n_rs != 5'd0 && n_rs == mq[i].dst) st = 1;
        if (n_rtu && n_rt != 5'd0 && n_rt == mq[i].dst) st = 1;
      end
    end
    return st;
  endfunction

  // One clock: drive inputs, predict this cycle's outputs, advance the model
  task automatic cyc();
    exp_t e;
    ent_t f;
    bit   st;
    int   sz;
    @(posedge Clk); #1;
    Reset                 = n_rst;
    sb_if.Issue_Valid     = n_iv;
    sb_if.Issue_RegWrite  = n_wr;
    sb_if.Issue_Dst       = n_dst;
    sb_if.Issue_IsLoad    = n_ld;
    sb_if.Src_rs          = n_rs;
    sb_if.Src_rt          = n_rt;
    sb_if.Src_rs_used     = n_rsu;
    sb_if.Src_rt_used     = n_rtu;
    sb_if.Retire_Valid    = n_rv;
    sb_if.Retire_Dst      = n_rd;
    sb_if.Kill_Young      = n_kill;
    if (n_rst) begin
      mq.delete();
      m_err = 0;
    end
    st      = model_stall();
    e.stall = st;
    e.cnt   = mq.size();
    e.full  = (mq.size() == DEPTH);
    e.err   = m_err;
    e.id    = step_no;
    eq.push_back(e);
    step_no++;
    if (!n_rst) begin
      sz = mq.size();
      if (n_rv && sz == 0) m_err = 1;
      if (n_kill && sz == 0) m_err = 1;
      if (n_rv && n_kill && sz == 1) begin
        mq.delete();
      end else begin
        if (n_rv && sz > 0) begin
          f = mq.pop_front();
          if (f.wr && f.dst != 5'd0 && f.dst != n_rd) m_err = 1;
        end
        if (n_kill && mq.size() > 0 && sz > 0) void'(mq.pop_back());
      end
      if (n_iv && !st) begin
        f.dst = n_dst; f.wr = n_wr; f.ld = n_ld;
        mq.push_back(f);
      end
    end
  endtask

  // Monitor: compare each prediction against the DUT on the falling edge
  always @(negedge Clk) begin
    exp_t e;
    if (eq.size() > 0) begin
      e = eq.pop_front();
      chk("stall", int'(sb_if.Stall), int'(e.stall), e.id);
      chk("count", int'(sb_if.Pending_Count), e.cnt, e.id);
      chk("full", int'(sb_if.Full), int'(e.full), e.id);
      chk("error", int'(sb_if.Error), int'(e.err), e.id);
    end
  end

  initial begin
    clr();
    sb_if.Issue_Valid = 0; sb_if.Issue_RegWrite = 0; sb_if.Issue_Dst = 0;
    sb_if.Issue_IsLoad = 0; sb_if.Src_rs = 0; sb_if.Src_rt = 0;
    sb_if.Src_rs_used = 0; sb_if.Src_rt_used = 0; sb_if.Retire_Valid = 0;
    sb_if.Retire_Dst = 0; sb_if.Kill_Young = 0;

    // Reset
    n_rst = 1; cyc(); cyc();
    clr(); cyc();

    // Load-use on $t0
    n_iv = 1; n_wr = 1; n_dst = 5'd8; n_ld = 1; cyc();
    clr(); n_rs = 5'd8; n_rsu = 1; cyc();
    n_rv = 1; n_rd = 5'd8; cyc();
    clr(); n_rs = 5'd8; n_rsu = 1; cyc();

    // $zero destination is never a hazard and never checked at retire
    clr(); n_iv = 1; n_wr = 1; n_dst = 5'd0; n_ld = 1; cyc();
    clr(); n_rs = 5'd0; n_rsu = 1; cyc();
    clr(); n_rv = 1; n_rd = 5'd5; cyc();
    clr(); cyc();

    // Fill to DEPTH, then retire+issue under Full
    for (int i = 1; i <= 4; i++) begin
      clr(); n_iv = 1; n_wr = 1; n_dst = 5'(i); cyc();
    end
    clr(); cyc();
    clr(); n_iv = 1; n_wr = 1; n_dst = 5'd5; n_rv = 1; n_rd = 5'd1; cyc();
    clr(); n_iv = 1; n_wr = 1; n_dst = 5'd5; cyc();
    for (int i = 2; i <= 5; i++) begin
      clr(); n_rv = 1; n_rd = 5'(i); cyc();
    end

    // Kill the youngest while issuing a replacement
    clr(); n_iv = 1; n_wr = 1; n_dst = 5'd9; n_ld = 1; cyc();
    clr(); n_iv = 1; n_wr = 1; n_dst = 5'd10; n_kill = 1; cyc();
    clr(); n_rt = 5'd9; n_rtu = 1; cyc();
    clr(); n_rv = 1; n_rd = 5'd10; cyc();

    // Retire on empty sets sticky Error
    clr(); n_rv = 1; n_rd = 5'd3; cyc();
    clr(); n_iv = 1; n_wr = 1; n_dst = 5'd7; cyc();
    clr(); n_rv = 1; n_rd = 5'd7; cyc();
    clr(); cyc();
    clr(); n_rst = 1; cyc();
    clr(); cyc();

    // Single entry retired and killed together
    clr(); n_iv = 1; n_wr = 1; n_dst = 5'd12; cyc();
    clr(); n_rv = 1; n_rd = 5'd30; n_kill = 1; cyc();
    clr(); cyc();

    // Steady-state issue/retire across pointer wrap, then reset mid-stream
    clr(); n_iv = 1; n_wr = 1; n_dst = 5'd11; cyc();
    for (int i = 0; i < 10; i++) begin
      clr(); n_iv = 1; n_wr = 1; n_dst = 5'(12 + i); n_ld = 1'(i % 2);
      n_rv = 1; n_rd = mq[0].dst; cyc();
    end
    clr(); n_iv = 1; n_wr = 1; n_dst = 5'd25; cyc();
    clr(); n_rst = 1; cyc();
    clr(); cyc();

    // Randomized traffic
    for (int k = 0; k < 500; k++) begin
      clr();
      n_rst  = ($urandom_range(0, 99) == 0) || (k % 80 == 79);
      n_iv   = 1'($urandom_range(0, 1));
      n_wr   = ($urandom_range(0, 3) != 0);
      n_dst  = 5'($urandom_range(0, 12));
      n_ld   = 1'($urandom_range(0, 1));
      n_rs   = 5'($urandom_range(0, 12));
      n_rt   = 5'($urandom_range(0, 12));
      n_rsu  = 1'($urandom_range(0, 1));
      n_rtu  = 1'($urandom_range(0, 1));
      n_rv   = ($urandom_range(0, 2) == 0);
      n_rd   = (mq.size() > 0 && $urandom_range(0, 15) != 0) ? mq[0].dst
                                                              : 5'($urandom_range(0, 31));
      n_kill = ($urandom_range(0, 9) == 0);
      cyc();
    end

    clr(); cyc();
    repeat (2) @(posedge Clk);
    @(negedge Clk); #1;
    chk("drain", eq.size(), 0, step_no);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
